// File: rtl/serial_send_sched_if.sv
// Requester/serializer-side bundle of the LVDS word scheduler.
// The scheduler uses the slave view; the requester side drives through the master view.
interface serial_send_sched_if #(
    parameter int NREQ = 4
);
    logic                 RETRAIN;
    logic [NREQ-1:0]      REQ;
    logic [4*NREQ-1:0]    LEN;
    logic [16*NREQ-1:0]   WDATA;
    logic [NREQ-1:0]      GNT;
    logic [NREQ-1:0]      WACK;
    logic [15:0]          DOUT;
    logic                 LINK_UP;

    modport master (
        output RETRAIN, REQ, LEN, WDATA,
        input  GNT, WACK, DOUT, LINK_UP
    );

    modport slave (
        input  RETRAIN, REQ, LEN, WDATA,
        output GNT, WACK, DOUT, LINK_UP
    );
endinterface

// File: rtl/serial_send_sched.sv
// Round-robin word scheduler for the LVDS serial transmit path: link training,
// header-framed bursts and idle comma fill, one word per CLKF edge.
module serial_send_sched #(
    parameter int          NREQ        = 4,
    parameter int          TRAIN_WORDS = 64,
    parameter logic [15:0] TRAIN_PAT   = 16'hF0F0,
    parameter logic [15:0] COMMA       = 16'hBC5A,
    parameter logic [7:0]  HDR_TAG     = 8'hA5
) (
    input  logic                CLKF,
    input  logic                RSTXF,
    serial_send_sched_if.slave  bus
);

    localparam int CW = (TRAIN_WORDS > 16) ? $clog2(TRAIN_WORDS) : 4;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] TRAIN_INIT = CW'(TRAIN_WORDS - 1);
    // The IDLE edge that launches a retrain already sends the first pattern word.
    localparam logic [CW-1:0] RETRAIN_INIT = CW'((TRAIN_WORDS > 1) ? (TRAIN_WORDS - 2) : 0);
    localparam logic [NREQ-1:0] GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      ptr_q;
    logic            rt_pend_q;
    logic [15:0]     dout_q;
    logic [NREQ-1:0] gnt_q;
    logic            link_q;

    logic [1:0]      win_s;
    logic            found_s;
    logic [3:0]      len_win_s;
    logic [15:0]     wdata_cur_s;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        win_s   = ptr_q;
        found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int   idx;
            logic hit;
            idx     = (int'(ptr_q) + k) % NREQ;
            hit     = bus.REQ[idx];
            win_s   = (!found_s && hit) ? 2'(idx) : win_s;
            found_s = found_s | hit;
        end
    end

    assign len_win_s   = bus.LEN[4*int'(win_s) +: 4];
    assign wdata_cur_s = bus.WDATA[16*int'(ptr_q) +: 16];

    // Scheduler FSM; every edge loads a word into DOUT.
    always_ff @(posedge CLKF or negedge RSTXF) begin
        if (!RSTXF) begin
            state_q   <= ST_TRAIN;
            cnt_q     <= TRAIN_INIT;
            ptr_q     <= 2'(NREQ - 1);
            rt_pend_q <= 1'b0;
            dout_q    <= 16'h0000;
            gnt_q     <= '0;
            link_q    <= 1'b0;
        end else begin
            rt_pend_q <= rt_pend_q | bus.RETRAIN;
            case (state_q)
                ST_TRAIN: begin
                    dout_q <= TRAIN_PAT;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        link_q  <= 1'b1;
                    end else begin
                        state_q <= ST_TRAIN;
                    end
                end
                ST_IDLE: begin
                    if (rt_pend_q) begin
                        state_q   <= ST_TRAIN;
                        cnt_q     <= RETRAIN_INIT;
                        rt_pend_q <= bus.RETRAIN;
                        link_q    <= 1'b0;
                        dout_q    <= TRAIN_PAT;
                    end else if (found_s) begin
                        gnt_q   <= GNT_ONE << win_s;
                        ptr_q   <= win_s;
                        cnt_q   <= CW'(len_win_s);
                        dout_q  <= {HDR_TAG, 2'b00, win_s, len_win_s};
                        state_q <= ST_DATA;
                    end else begin
                        dout_q <= COMMA;
                    end
                end
                ST_DATA: begin
                    dout_q <= wdata_cur_s;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_TRAIN;
                    cnt_q   <= TRAIN_INIT;
                    gnt_q   <= '0;
                    link_q  <= 1'b0;
                    dout_q  <= TRAIN_PAT;
                end
            endcase
        end
    end

    assign bus.DOUT    = dout_q;
    assign bus.GNT     = gnt_q;
    assign bus.WACK    = gnt_q & {NREQ{state_q == ST_DATA}};
    assign bus.LINK_UP = link_q;

endmodule

// File: tb/tb_serial_send_sched.sv
// Directed-vector bench for serial_send_sched with TRAIN_WORDS=4, NREQ=4.
module tb_serial_send_sched;

    logic CLKF;
    logic RSTXF;

    serial_send_sched_if #(.NREQ(4)) bus();

    serial_send_sched #(
        .NREQ(4), .TRAIN_WORDS(4), .TRAIN_PAT(16'hF0F0),
        .COMMA(16'hBC5A), .HDR_TAG(8'hA5)
    ) dut (
        .CLKF(CLKF),
        .RSTXF(RSTXF),
        .bus(bus)
    );

    initial CLKF = 1'b0;
    always #5 CLKF = ~CLKF;

    typedef struct {
        string       nm;
        logic        rt;
        logic [3:0]  req;
        logic [15:0] len;
        logic [63:0] wd;
        logic [15:0] dout;
        logic [3:0]  gnt;
        logic        link;
    } vec_t;

    vec_t vq[$];
    int   checks;
    int   errors;

    function automatic void add(input string nm, input logic rt, input logic [3:0] req,
                                input logic [15:0] len, input logic [63:0] wd,
                                input logic [15:0] dout, input logic [3:0] gnt,
                                input logic link);
        vec_t v;
        v.nm = nm; v.rt = rt; v.req = req; v.len = len; v.wd = wd;
        v.dout = dout; v.gnt = gnt; v.link = link;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rt, input logic [3:0] req, input logic [15:0] len,
                         input logic [63:0] wd);
        bus.RETRAIN = rt;
        bus.REQ     = req;
        bus.LEN     = len;
        bus.WDATA   = wd;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] dout, input logic [3:0] gnt,
                           input logic [3:0] wack, input logic link);
        chk({nm, ".dout"}, 64'(bus.DOUT), 64'(dout));
        chk({nm, ".gnt"},  64'(bus.GNT),  64'(gnt));
        chk({nm, ".wack"}, 64'(bus.WACK), 64'(wack));
        chk({nm, ".link"}, 64'(bus.LINK_UP), 64'(link));
    endtask

    logic [15:0] rr_hdr [5];

    initial begin
        checks = 0;
        errors = 0;
        RSTXF  = 1'b0;
        drive(1'b0, 4'h0, 16'h0000, 64'h0);

        // Training after reset, then idle comma.
        for (int k = 1; k <= 4; k++) add("train", 1'b0, 4'h0, 16'h0, 64'h0, 16'hF0F0, 4'h0, k == 4);
        add("idle", 1'b0, 4'h0, 16'h0, 64'h0, 16'hBC5A, 4'h0, 1'b1);

        // Round-robin from reset pointer: channel 0 first, one data word each.
        rr_hdr = '{16'hA500, 16'hA510, 16'hA520, 16'hA530, 16'hA500};
        for (int c = 0; c < 5; c++) begin
            add("rr_hdr", 1'b0, 4'hF, 16'h0, 64'hD003_D002_D001_D000, rr_hdr[c], 4'b0001 << (c % 4), 1'b1);
            add("rr_dat", 1'b0, 4'hF, 16'h0, 64'hD003_D002_D001_D000, 16'hD000 + 16'(c % 4), 4'h0, 1'b1);
        end
        add("rr_end", 1'b0, 4'h0, 16'h0, 64'h0, 16'hBC5A, 4'h0, 1'b1);

        // Single burst on channel 2, LEN=2.
        add("sb_hdr", 1'b0, 4'b0100, 16'h0200, 64'h0, 16'hA522, 4'b0100, 1'b1);
        add("sb_d1", 1'b0, 4'h0, 16'h0, 64'h0000_0001_0000_0000, 16'h0001, 4'b0100, 1'b1);
        add("sb_d2", 1'b0, 4'h0, 16'h0, 64'h0000_0002_0000_0000, 16'h0002, 4'b0100, 1'b1);
        add("sb_d3", 1'b0, 4'h0, 16'h0, 64'h0000_0003_0000_0000, 16'h0003, 4'h0, 1'b1);
        add("sb_end", 1'b0, 4'h0, 16'h0, 64'h0, 16'hBC5A, 4'h0, 1'b1);

        // Retrain during a LEN=3 burst on channel 3, channel 0 pending.
        add("rt_hdr", 1'b0, 4'b1001, 16'h3001, 64'h0, 16'hA533, 4'b1000, 1'b1);
        add("rt_d1", 1'b0, 4'b0001, 16'h3001, 64'h3001_0000_0000_0000, 16'h3001, 4'b1000, 1'b1);
        add("rt_d2", 1'b1, 4'b0001, 16'h3001, 64'h3002_0000_0000_0000, 16'h3002, 4'b1000, 1'b1);
        add("rt_d3", 1'b0, 4'b0001, 16'h3001, 64'h3003_0000_0000_0000, 16'h3003, 4'b1000, 1'b1);
        add("rt_d4", 1'b0, 4'b0001, 16'h3001, 64'h3004_0000_0000_0000, 16'h3004, 4'h0, 1'b1);
        for (int k = 1; k <= 4; k++) add("rt_train", 1'b0, 4'b0001, 16'h0001, 64'h0, 16'hF0F0, 4'h0, k == 4);
        add("rt_pend_hdr", 1'b0, 4'b0001, 16'h0001, 64'h0, 16'hA501, 4'b0001, 1'b1);
        add("rt_pend_d1", 1'b0, 4'h0, 16'h0, 64'h0000_0000_0000_0A01, 16'h0A01, 4'b0001, 1'b1);
        add("rt_pend_d2", 1'b0, 4'h0, 16'h0, 64'h0000_0000_0000_0A02, 16'h0A02, 4'h0, 1'b1);
        add("rt_end", 1'b0, 4'h0, 16'h0, 64'h0, 16'hBC5A, 4'h0, 1'b1);

        // REQ[1] dropped right after grant of a 16-word burst.
        add("rd_hdr", 1'b0, 4'b0010, 16'h00F0, 64'h0, 16'hA51F, 4'b0010, 1'b1);
        for (int k = 0; k < 16; k++)
            add("rd_dat", 1'b0, 4'h0, 16'h0, {32'h0, 16'h1100 + 16'(k), 16'h0},
                16'h1100 + 16'(k), (k < 15) ? 4'b0010 : 4'h0, 1'b1);
        add("rd_next_hdr", 1'b0, 4'b0111, 16'h0000, 64'h0, 16'hA520, 4'b0100, 1'b1);
        add("rd_next_dat", 1'b0, 4'h0, 16'h0, 64'h0000_2222_0000_0000, 16'h2222, 4'h0, 1'b1);
        add("rd_end", 1'b0, 4'h0, 16'h0, 64'h0, 16'hBC5A, 4'h0, 1'b1);

        // Reset values, held across edges.
        repeat (3) @(negedge CLKF);
        chk_out("reset", 16'h0000, 4'h0, 4'h0, 1'b0);
        RSTXF = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rt, vq[i].req, vq[i].len, vq[i].wd);
            @(posedge CLKF);
            @(negedge CLKF);
            chk_out($sformatf("%s[%0d]", vq[i].nm, i), vq[i].dout, vq[i].gnt, vq[i].gnt, vq[i].link);
        end

        // Asynchronous reset in the middle of a burst.
        drive(1'b0, 4'b0001, 16'h0005, 64'h0000_0000_0000_5555);
        @(posedge CLKF);
        @(negedge CLKF);
        chk_out("ar_hdr", 16'hA505, 4'b0001, 4'b0001, 1'b1);
        drive(1'b0, 4'h0, 16'h0, 64'h0000_0000_0000_5555);
        @(posedge CLKF);
        @(negedge CLKF);
        chk_out("ar_dat", 16'h5555, 4'b0001, 4'b0001, 1'b1);
        #2 RSTXF = 1'b0;
        #1 chk_out("ar_async", 16'h0000, 4'h0, 4'h0, 1'b0);
        @(negedge CLKF);
        chk_out("ar_held", 16'h0000, 4'h0, 4'h0, 1'b0);
        RSTXF = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLKF);
            @(negedge CLKF);
            chk_out($sformatf("ar_train%0d", k), 16'hF0F0, 4'h0, 4'h0, k == 4);
        end
        @(posedge CLKF);
        @(negedge CLKF);
        chk_out("ar_idle", 16'hBC5A, 4'h0, 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
